// File: rtl/reg_wr_arbiter.sv
// Round-robin write-port arbiter for the shared 16-bit register bank.
// Grants one requester per cycle onto the bank D/CE bus and sequences bank-wide clears.
module reg_wr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_REGS = 6,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     C,
    input  logic                     CLR,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*16-1:0]      req_data,
    input  logic                     clr_req,
    output logic [N_REQ-1:0]         ack,
    output logic                     wr_err,
    output logic [15:0]              bank_d,
    output logic [N_REGS-1:0]        bank_ce,
    output logic                     bank_clr,
    output logic                     clr_done
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClear
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               wr_err_q, wr_err_d;
    logic [15:0]        bank_d_q, bank_d_d;
    logic [N_REGS-1:0]  bank_ce_q, bank_ce_d;
    logic               bank_clr_q, bank_clr_d;
    logic               clr_done_q, clr_done_d;

    logic [N_REQ-1:0]   eligible;
    logic               found;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   grant;
    logic [ADDR_W-1:0]  grant_addr;
    logic [15:0]        grant_data;
    logic               addr_ok;

    // Round-robin search starting at the pointer; a requester acked this cycle
    // is masked so its still-high valid is not granted twice.
    always_comb begin
        eligible = req_valid & ~ack_q;
        found    = 1'b0;
        grant    = '0;
        idx      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == PTR_W'(i)) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_data = req_data[i*16 +: 16];
            end
        end
        addr_ok = (32'(grant_addr) < N_REGS);
    end

    always_comb begin
        state_d    = StIdle;
        ptr_d      = ptr_q;
        ack_d      = '0;
        wr_err_d   = 1'b0;
        bank_d_d   = '0;
        bank_ce_d  = '0;
        bank_clr_d = 1'b0;
        clr_done_d = 1'b0;

        // Clear wins over writes; a held clr_req is ignored for the cycle after it completes.
        if (clr_req && (state_q != StClear)) begin
            state_d    = StClear;
            bank_clr_d = 1'b1;
            clr_done_d = 1'b1;
        end else if (found) begin
            state_d      = StWrite;
            ack_d[grant] = 1'b1;
            bank_d_d     = grant_data;
            if (addr_ok) begin
                for (int unsigned r = 0; r < N_REGS; r++) begin
                    bank_ce_d[r] = (grant_addr == ADDR_W'(r));
                end
            end else begin
                wr_err_d = 1'b1;
            end
            ptr_d = (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge C) begin
        if (CLR) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            ack_q      <= '0;
            wr_err_q   <= 1'b0;
            bank_d_q   <= '0;
            bank_ce_q  <= '0;
            bank_clr_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            wr_err_q   <= wr_err_d;
            bank_d_q   <= bank_d_d;
            bank_ce_q  <= bank_ce_d;
            bank_clr_q <= bank_clr_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign ack      = ack_q;
    assign wr_err   = wr_err_q;
    assign bank_d   = bank_d_q;
    assign bank_ce  = bank_ce_q;
    assign bank_clr = bank_clr_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios plus random traffic against a cycle-level
// behavioural model, with a behavioural register bank hung off the DUT outputs.
module tb_reg_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_REGS = 6;
    localparam int ADDR_W = 3;

    logic                    C = 1'b0;
    logic                    CLR = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*ADDR_W-1:0] req_addr = '0;
    logic [N_REQ*16-1:0]     req_data = '0;
    logic                    clr_req = 1'b0;
    logic [N_REQ-1:0]        ack;
    logic                    wr_err;
    logic [15:0]             bank_d;
    logic [N_REGS-1:0]       bank_ce;
    logic                    bank_clr;
    logic                    clr_done;

    reg_wr_arbiter #(
        .N_REQ  (N_REQ),
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W)
    ) dut (
        .C         (C),
        .CLR       (CLR),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_req   (clr_req),
        .ack       (ack),
        .wr_err    (wr_err),
        .bank_d    (bank_d),
        .bank_ce   (bank_ce),
        .bank_clr  (bank_clr),
        .clr_done  (clr_done)
    );

    always #5 C = ~C;

    // Register bank driven by the DUT
    logic [15:0] bank_q [N_REGS] = '{default: '0};
    always @(posedge C) begin
        for (int r = 0; r < N_REGS; r++) begin
            if (bank_clr) bank_q[r] <= '0;
            else if (bank_ce[r]) bank_q[r] <= bank_d;
        end
    end

    // Reference model state: expected outputs for the current cycle
    int               m_ptr = 0;
    logic [N_REQ-1:0] e_ack = '0;
    logic             e_err = 1'b0;
    logic [15:0]      e_d = '0;
    logic [N_REGS-1:0] e_ce = '0;
    logic             e_clr = 1'b0;
    logic             e_done = 1'b0;
    logic [15:0]      e_regs [N_REGS] = '{default: '0};
    bit               clr_auto_drop = 1'b1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [N_REQ-1:0]  n_ack;
        logic              n_err, n_clr, n_done;
        logic [15:0]       n_d;
        logic [N_REGS-1:0] n_ce;
        int                g;
        logic [ADDR_W-1:0] a;
        // the bank loads at this edge from what is on the outputs now
        for (int r = 0; r < N_REGS; r++) begin
            if (e_clr) e_regs[r] = '0;
            else if (e_ce[r]) e_regs[r] = e_d;
        end
        n_ack = '0; n_err = 0; n_clr = 0; n_done = 0; n_d = '0; n_ce = '0;
        if (CLR) begin
            m_ptr = 0;
        end else if (clr_req && !e_done) begin
            n_clr  = 1;
            n_done = 1;
        end else begin
            g = -1;
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (g < 0 && req_valid[i] && !e_ack[i]) g = i;
            end
            if (g >= 0) begin
                n_ack[g] = 1'b1;
                n_d = req_data[g*16 +: 16];
                a = req_addr[g*ADDR_W +: ADDR_W];
                if (int'(a) < N_REGS) n_ce = N_REGS'(1) << a;
                else n_err = 1'b1;
                m_ptr = (g + 1) % N_REQ;
            end
        end
        e_ack = n_ack; e_err = n_err; e_d = n_d; e_ce = n_ce; e_clr = n_clr; e_done = n_done;
        @(posedge C);
        #1;
        chk("ack", 32'(ack), 32'(e_ack));
        chk("wr_err", 32'(wr_err), 32'(e_err));
        chk("bank_d", 32'(bank_d), 32'(e_d));
        chk("bank_ce", 32'(bank_ce), 32'(e_ce));
        chk("bank_clr", 32'(bank_clr), 32'(e_clr));
        chk("clr_done", 32'(clr_done), 32'(e_done));
        for (int i = 0; i < N_REQ; i++) if (e_ack[i]) req_valid[i] = 1'b0;
        if (e_done && clr_auto_drop) clr_req = 1'b0;
    endtask

    task automatic chk_regs(input string tag);
        for (int r = 0; r < N_REGS; r++) chk(tag, 32'(bank_q[r]), 32'(e_regs[r]));
    endtask

    initial begin
        // Reset with all requesters valid
        req_addr  = {3'd3, 3'd2, 3'd1, 3'd0};
        req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_valid = 4'b1111;
        CLR = 1'b1;
        step(); chk("rst_ack0", 32'(ack), 0);
        step(); chk("rst_ack1", 32'(ack), 0);
        CLR = 1'b0;
        step(); chk("rr_ack0", 32'(ack), 32'h1);
        step(); chk("rr_ack1", 32'(ack), 32'h2);
        step(); chk("rr_ack2", 32'(ack), 32'h4);
        step(); chk("rr_ack3", 32'(ack), 32'h8);
        step(); chk("rr_idle", 32'(ack), 0);
        chk("reg0", 32'(bank_q[0]), 32'h1111);
        chk("reg1", 32'(bank_q[1]), 32'h2222);
        chk("reg2", 32'(bank_q[2]), 32'h3333);
        chk("reg3", 32'(bank_q[3]), 32'h4444);

        // Single write to register 2
        req_addr[2:0] = 3'd2; req_data[15:0] = 16'h1234; req_valid[0] = 1'b1;
        step();
        chk("w2_ce", 32'(bank_ce), 32'b000100);
        chk("w2_d", 32'(bank_d), 32'h1234);
        chk("w2_ack", 32'(ack), 32'h1);
        step(); chk("w2_ack_pulse", 32'(ack), 0);
        chk("w2_reg", 32'(bank_q[2]), 32'h1234);

        // Pointer wraps after grant to req3
        req_valid[3] = 1'b1;
        step(); chk("wrap_ack3", 32'(ack), 32'h8);
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        step(); chk("wrap_ack0", 32'(ack), 32'h1);
        step(); chk("wrap_ack2", 32'(ack), 32'h4);
        step();

        // Clear beats a simultaneous write, write follows with no bubble
        clr_req = 1'b1;
        req_addr[5:3] = 3'd1; req_data[31:16] = 16'hABCD; req_valid[1] = 1'b1;
        step();
        chk("clr_bank_clr", 32'(bank_clr), 1);
        chk("clr_done", 32'(clr_done), 1);
        chk("clr_no_ack", 32'(ack), 0);
        step();
        chk("clr_w_ce", 32'(bank_ce), 32'b000010);
        chk("clr_w_ack", 32'(ack), 32'h2);
        step();
        chk("clr_reg1", 32'(bank_q[1]), 32'hABCD);
        chk("clr_reg0", 32'(bank_q[0]), 0);
        chk("clr_reg2", 32'(bank_q[2]), 0);
        chk_regs("clr_regs");

        // Out-of-range address
        req_addr[8:6] = 3'd7; req_data[47:32] = 16'h5555; req_valid[2] = 1'b1;
        step();
        chk("oor_ack", 32'(ack), 32'h4);
        chk("oor_err", 32'(wr_err), 1);
        chk("oor_ce", 32'(bank_ce), 0);
        step();
        chk("oor_err_pulse", 32'(wr_err), 0);
        chk_regs("oor_regs");

        // Held clr_req re-arms after one masked cycle
        clr_auto_drop = 1'b0;
        clr_req = 1'b1;
        step(); chk("rearm_done0", 32'(clr_done), 1);
        step(); chk("rearm_mask", 32'(clr_done), 0);
        step(); chk("rearm_done1", 32'(clr_done), 1);
        clr_req = 1'b0;
        clr_auto_drop = 1'b1;
        step();

        // Reset in the middle of a write burst
        req_valid[0] = 1'b1; req_valid[1] = 1'b1;
        step(); chk("mid_ack0", 32'(ack), 32'h1);
        CLR = 1'b1;
        step(); chk("mid_rst_ack", 32'(ack), 0);
        CLR = 1'b0;
        step(); chk("mid_after_ack", 32'(ack), 32'h2);
        step();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_addr[i*ADDR_W +: ADDR_W] = 3'($urandom_range(0, 7));
                    req_data[i*16 +: 16] = 16'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (!clr_req && $urandom_range(0, 15) == 0) clr_req = 1'b1;
            clr_auto_drop = ($urandom_range(0, 3) != 0);
            CLR = ($urandom_range(0, 63) == 0);
            step();
            if (n % 16 == 15) chk_regs("rand_regs");
        end
        CLR = 1'b0; clr_req = 1'b0; req_valid = '0; clr_auto_drop = 1'b1;
        step(); step();
        chk_regs("final_regs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
